// File: rtl/filter_package.sv
// Shared definitions for the CDR digital loop filter.
// Holds the DCO code width, code/gain/accumulator types, the FSM state type and a
// saturating clamp helper used by both the integrator and the output stage.
package filter_package;

  localparam int unsigned DCO_CODE_WIDTH = 14;
  // Integrator needs headroom for +/-(2^W-1); output sum needs one bit more.
  localparam int unsigned INTEG_WIDTH    = DCO_CODE_WIDTH + 2;
  localparam int unsigned ACC_WIDTH      = DCO_CODE_WIDTH + 3;

  typedef logic        [DCO_CODE_WIDTH-1:0] dco_code_t;
  typedef logic signed [DCO_CODE_WIDTH-1:0] gain_t;
  typedef logic signed [INTEG_WIDTH-1:0]    integ_t;
  typedef logic signed [ACC_WIDTH-1:0]      acc_t;
  typedef logic signed [1:0]                err_t;

  localparam err_t ERR_NONE  = 2'sb00;
  localparam err_t ERR_LATE  = 2'sb01;  // +1
  localparam err_t ERR_EARLY = 2'sb11;  // -1

  localparam acc_t CODE_MAX  = acc_t'((1 << DCO_CODE_WIDTH) - 1);
  localparam acc_t INTEG_MIN = -CODE_MAX;

  typedef enum logic [1:0] {
    StReset,
    StInit,
    StRun
  } filter_state_e;

  function automatic acc_t sat_clamp(input acc_t value, input acc_t lo, input acc_t hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/lock_detector.sv
// Bang-bang lock indicator.
// Counts consecutive "balanced" phase-detector updates (zero error, sign flip, or first
// error after zero) and clears on two equal non-zero errors in a row.
// Ports: clk/rst (async active-high), update (accepted PD decision), err (-1/0/+1),
//        locked (registered, lock_cnt >= LOCK_COUNT).
module lock_detector
  import filter_package::*;
#(
  parameter int unsigned LOCK_COUNT     = 16,
  parameter int unsigned LOCK_CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  input  err_t err,
  output logic locked
);

  localparam logic [LOCK_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LOCK_CNT_WIDTH-1:0] CNT_THR = LOCK_CNT_WIDTH'(LOCK_COUNT);

  err_t                      err_prev_q;
  logic [LOCK_CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
  logic                      locked_q;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (err != ERR_NONE && err == err_prev_q) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != CNT_MAX) begin
      lock_cnt_d = lock_cnt_q + LOCK_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_prev_q <= ERR_NONE;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else if (update) begin
      err_prev_q <= err;
      lock_cnt_q <= lock_cnt_d;
      // Compare against the new count so locked moves on the same edge as stage 1.
      locked_q   <= (lock_cnt_d >= CNT_THR);
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/digital_loop_filter.sv
// Proportional-integral loop filter between the bang-bang phase detector and the DCO.
// Stage 1 updates the clamped integrator and proportional term from each PD decision;
// stage 2 adds them to dco_init and clamps into the unsigned DCO code range.
// Ports: clk, rst (async active-high), dco_init (start code), kp_lf/ki_lf (signed gains),
//        pd_valid/pd_early/pd_late (PD decision), dco_code/dco_valid (output code and
//        update pulse), sat (last output clamped), locked (bang-bang lock indication).
module digital_loop_filter
  import filter_package::*;
#(
  parameter int unsigned LOCK_COUNT     = 16,
  parameter int unsigned LOCK_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic        [DCO_CODE_WIDTH-1:0] dco_init,
  input  logic signed [DCO_CODE_WIDTH-1:0] kp_lf,
  input  logic signed [DCO_CODE_WIDTH-1:0] ki_lf,
  input  logic                             pd_valid,
  input  logic                             pd_early,
  input  logic                             pd_late,
  output logic        [DCO_CODE_WIDTH-1:0] dco_code,
  output logic                             dco_valid,
  output logic                             sat,
  output logic                             locked
);

  filter_state_e state_q, state_d;
  logic          load_init, run;

  err_t   err;
  logic   update;
  acc_t   ki_term, kp_term, integ_sum, integ_clamped;
  acc_t   out_sum, out_clamped;
  integ_t integ_q, p_q;
  logic   s1_valid_q;

  dco_code_t dco_code_q;
  logic      dco_valid_q, sat_q;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StReset;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StInit;
      StInit:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StReset;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load_init = 1'b0;
    run       = 1'b0;
    unique case (state_q)
      StInit:  load_init = 1'b1;
      StRun:   run       = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    err = ERR_NONE;
    if (pd_late && !pd_early)      err = ERR_LATE;
    else if (pd_early && !pd_late) err = ERR_EARLY;
  end

  assign update = run && pd_valid;

  always_comb begin
    ki_term = '0;
    kp_term = '0;
    case (err)
      ERR_LATE: begin
        ki_term = acc_t'(ki_lf);
        kp_term = acc_t'(kp_lf);
      end
      ERR_EARLY: begin
        ki_term = -acc_t'(ki_lf);
        kp_term = -acc_t'(kp_lf);
      end
      default: ;
    endcase
  end

  // Integrator is clamped to the full code range to stop wind-up.
  assign integ_sum     = acc_t'(integ_q) + ki_term;
  assign integ_clamped = sat_clamp(integ_sum, INTEG_MIN, CODE_MAX);

  assign out_sum     = acc_t'(dco_init) + acc_t'(integ_q) + acc_t'(p_q);
  assign out_clamped = sat_clamp(out_sum, '0, CODE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q     <= '0;
      p_q         <= '0;
      s1_valid_q  <= 1'b0;
      dco_code_q  <= '0;
      dco_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= update;
      dco_valid_q <= 1'b0;
      if (update) begin
        integ_q <= integ_clamped[INTEG_WIDTH-1:0];
        p_q     <= kp_term[INTEG_WIDTH-1:0];
      end
      if (load_init) begin
        dco_code_q  <= dco_init;
        dco_valid_q <= 1'b1;
        sat_q       <= 1'b0;
      end else if (s1_valid_q) begin
        dco_code_q  <= out_clamped[DCO_CODE_WIDTH-1:0];
        dco_valid_q <= 1'b1;
        sat_q       <= (out_clamped != out_sum);
      end
    end
  end

  lock_detector #(
    .LOCK_COUNT     (LOCK_COUNT),
    .LOCK_CNT_WIDTH (LOCK_CNT_WIDTH)
  ) u_lock_detector (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .err    (err),
    .locked (locked)
  );

  assign dco_code  = dco_code_q;
  assign dco_valid = dco_valid_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_digital_loop_filter.sv
// Self-checking bench for digital_loop_filter: directed scenarios plus randomized
// decisions and gains, compared against an integer-arithmetic reference model.
module tb_digital_loop_filter;

  localparam int CODE_MAX = 16383;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic        [13:0] dco_init = '0;
  logic signed [13:0] kp_lf = '0;
  logic signed [13:0] ki_lf = '0;
  logic               pd_valid = 1'b0;
  logic               pd_early = 1'b0;
  logic               pd_late = 1'b0;
  logic        [13:0] dco_code;
  logic               dco_valid;
  logic               sat;
  logic               locked;

  digital_loop_filter #(
    .LOCK_COUNT     (16),
    .LOCK_CNT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dco_init  (dco_init),
    .kp_lf     (kp_lf),
    .ki_lf     (ki_lf),
    .pd_valid  (pd_valid),
    .pd_early  (pd_early),
    .pd_late   (pd_late),
    .dco_code  (dco_code),
    .dco_valid (dco_valid),
    .sat       (sat),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int code;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   kp_m, ki_m, init_m, integ_m, p_m, err_prev_m, lock_m, cyc, last_code;
  bit   last_sat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Assert reset, confirm the reset state, then release with a fresh model.
  task automatic do_reset();
    exp_t item;
    rst      = 1'b1;
    pd_valid = 1'b0;
    pd_early = 1'b0;
    pd_late  = 1'b0;
    #1;
    check_eq("rst_code", dco_code, 0);
    check_eq("rst_valid", dco_valid, 0);
    check_eq("rst_sat", sat, 0);
    check_eq("rst_locked", locked, 0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", dco_valid, 0);
    check_eq("rst_hold_code", dco_code, 0);
    dco_init = init_m[13:0];
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    integ_m    = 0;
    p_m        = 0;
    err_prev_m = 0;
    lock_m     = 0;
    cyc        = 0;
    last_code  = 0;
    last_sat   = 1'b0;
    // Edge 1 leaves RESET, edge 2 leaves INIT and publishes dco_init.
    item.due  = 2;
    item.code = init_m;
    item.sat  = 1'b0;
    exp_q.push_back(item);
  endtask

  // One clock: drive a decision, advance the model, then compare.
  task automatic step(input bit v, input bit ea, input bit la, input bit chk);
    int   e, raw;
    bit   exp_v;
    exp_t item;
    pd_valid = v;
    pd_early = ea;
    pd_late  = la;
    kp_lf    = kp_m[13:0];
    ki_lf    = ki_m[13:0];
    @(posedge clk);
    cyc++;
    if (v && cyc >= 3) begin
      e = (la && !ea) ? 1 : ((ea && !la) ? -1 : 0);
      integ_m = clampi(integ_m + ki_m * e, -CODE_MAX, CODE_MAX);
      p_m     = kp_m * e;
      raw     = init_m + integ_m + p_m;
      item.due  = cyc + 1;
      item.code = clampi(raw, 0, CODE_MAX);
      item.sat  = (raw < 0) || (raw > CODE_MAX);
      exp_q.push_back(item);
      if (e != 0 && e == err_prev_m) lock_m = 0;
      else if (lock_m < 255)         lock_m++;
      err_prev_m = e;
    end
    #1;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (exp_v) begin
      last_code = exp_q[0].code;
      last_sat  = exp_q[0].sat;
      void'(exp_q.pop_front());
    end
    if (chk) begin
      check_eq("dco_valid", dco_valid, exp_v);
      check_eq("dco_code", dco_code, last_code);
      check_eq("sat", sat, last_sat);
      check_eq("locked", locked, lock_m >= 16);
    end
  endtask

  initial begin
    kp_m   = 0;
    ki_m   = 0;
    init_m = 6700;
    #2;

    // Reset release and INIT load, code holds with no decisions.
    do_reset();
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("init_code", dco_code, 6700);

    // Single late then single early.
    kp_m = 256;
    ki_m = 1;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("late_code", dco_code, 6957);
    check_eq("late_valid", dco_valid, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("early_code", dco_code, 6444);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Long late run drives both clamps.
    for (int i = 0; i < 20000; i++) begin
      step(1'b1, 1'b0, 1'b1, (i % 1000 == 0) || (i > 19990));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("sat_hi_code", dco_code, CODE_MAX);
    check_eq("sat_hi_flag", sat, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("unwind_code", dco_code, CODE_MAX);
    check_eq("unwind_sat", sat, 1);

    // Alternating decisions build lock; two equal lates drop it.
    init_m = 6700;
    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i[0], ~i[0], 1'b1);
      if (i == 14) check_eq("lock_after15", locked, 0);
    end
    check_eq("lock_after16", locked, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("lock_flip_keep", locked, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("lock_drop", locked, 0);

    // Both flags set: zero error, code becomes init + integrator, still pulses.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("both_code", dco_code, 6700 + integ_m);
    check_eq("both_valid", dco_valid, 1);

    // Reset with an update in flight.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reinit_code", dco_code, 6700);

    // Randomized decisions, gains and start code.
    for (int r = 0; r < 4; r++) begin
      init_m = int'($urandom_range(0, CODE_MAX));
      do_reset();
      for (int i = 0; i < 400; i++) begin
        kp_m = int'($urandom_range(0, 16383)) - 8192;
        ki_m = int'($urandom_range(0, 16383)) - 8192;
        if (i % 3 == 0) ki_m = ki_m / 64;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
